// File: rtl/lab2_timer_ctrl_if.sv
// Button/preset inputs, counter feedback and counter-control outputs of the
// kitchen-timer controller, bundled for the controller and its driver.
interface lab2_timer_ctrl_if;
  logic       GO;
  logic       SET;
  logic       CANCEL;
  logic [3:0] PRESET_D1;
  logic [3:0] PRESET_D2;
  logic [3:0] Q1;
  logic [3:0] Q2;
  logic [3:0] CNT_D1;
  logic [3:0] CNT_D2;
  logic       CNT_LOAD;
  logic       CNT_ENABLE;
  logic       CNT_UP;
  logic       CNT_CLR;
  logic       ALARM;
  logic [2:0] STATE;

  modport master (
    output GO, SET, CANCEL, PRESET_D1, PRESET_D2, Q1, Q2,
    input  CNT_D1, CNT_D2, CNT_LOAD, CNT_ENABLE, CNT_UP, CNT_CLR, ALARM, STATE
  );

  modport slave (
    input  GO, SET, CANCEL, PRESET_D1, PRESET_D2, Q1, Q2,
    output CNT_D1, CNT_D2, CNT_LOAD, CNT_ENABLE, CNT_UP, CNT_CLR, ALARM, STATE
  );
endinterface

// File: rtl/lab2_timer_ctrl.sv
// Kitchen-timer sequencer for the two-digit BCD down counter: preset load,
// prescaled count-down pulses, pause/resume, timed alarm and cancel/clear.
module lab2_timer_ctrl #(
  parameter int TICK_DIV     = 100000000,
  parameter int ALARM_CYCLES = 300000000
) (
  input logic              CLK,
  input logic              RST,
  lab2_timer_ctrl_if.slave tif
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_MAX = AW'(ALARM_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READY = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_ALARM = 3'd5,
    S_CLEAR = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      btn, btn_prev_q, btn_prev_d, ev;
  logic [PW-1:0]   presc_q, presc_d;
  logic [AW-1:0]   acnt_q, acnt_d;
  logic [1:0][3:0] dig_q, dig_d, pre;
  logic            load_q, load_d, en_q, en_d, clr_q, clr_d, alarm_q, alarm_d;
  logic            ev_go, ev_set, ev_cancel, q_zero;

  // bit order {CANCEL, SET, GO}; an event is a rising level seen this edge
  assign btn       = {tif.CANCEL, tif.SET, tif.GO};
  assign ev        = btn & ~btn_prev_q;
  assign ev_go     = ev[0];
  assign ev_set    = ev[1];
  assign ev_cancel = ev[2];
  assign q_zero    = ({tif.Q2, tif.Q1} == 8'h00);
  assign pre       = {tif.PRESET_D2, tif.PRESET_D1};

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    acnt_d     = acnt_q;
    dig_d      = dig_q;
    en_d       = 1'b0;
    btn_prev_d = btn;
    case (state_q)
      S_IDLE: begin
        if (ev_cancel)   state_d = S_CLEAR;
        else if (ev_set) state_d = S_LOAD;
      end
      S_LOAD: state_d = S_READY;
      S_READY: begin
        if (ev_cancel)   state_d = S_CLEAR;
        else if (ev_set) state_d = S_LOAD;
        else if (ev_go) begin
          state_d = S_RUN;
          presc_d = '0;
        end
      end
      S_RUN: begin
        // the prescaler only advances on edges that stay in RUN, so a pause
        // landing on the tick edge defers the pulse instead of dropping it
        if (ev_cancel)   state_d = S_CLEAR;
        else if (q_zero) state_d = S_ALARM;
        else if (ev_go)  state_d = S_PAUSE;
        else begin
          presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
          en_d    = (presc_q == PRESC_MAX);
        end
      end
      S_PAUSE: begin
        if (ev_cancel) state_d = S_CLEAR;
        else if (ev_set) begin
          state_d = S_LOAD;
          presc_d = '0;
        end
        else if (ev_go) state_d = S_RUN;
      end
      S_ALARM: begin
        if (ev_go || ev_cancel || acnt_q == ALARM_MAX) state_d = S_IDLE;
        else acnt_d = acnt_q + 1'b1;
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ALARM && state_q != S_ALARM) acnt_d = '0;
    if (state_d == S_LOAD) begin
      for (int i = 0; i < 2; i++) dig_d[i] = (pre[i] > 4'd9) ? 4'd9 : pre[i];
    end

    load_d  = (state_d == S_LOAD);
    en_d    = en_d | load_d;
    clr_d   = (state_d != S_CLEAR);
    alarm_d = (state_d == S_ALARM);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      btn_prev_q <= '0;
      presc_q    <= '0;
      acnt_q     <= '0;
      dig_q      <= '0;
      load_q     <= 1'b0;
      en_q       <= 1'b0;
      clr_q      <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_prev_q <= btn_prev_d;
      presc_q    <= presc_d;
      acnt_q     <= acnt_d;
      dig_q      <= dig_d;
      load_q     <= load_d;
      en_q       <= en_d;
      clr_q      <= clr_d;
      alarm_q    <= alarm_d;
    end
  end

  assign tif.CNT_D1     = dig_q[0];
  assign tif.CNT_D2     = dig_q[1];
  assign tif.CNT_LOAD   = load_q;
  assign tif.CNT_ENABLE = en_q;
  assign tif.CNT_UP     = 1'b0;
  assign tif.CNT_CLR    = clr_q;
  assign tif.ALARM      = alarm_q;
  assign tif.STATE      = state_q;
endmodule

// File: tb/tb_lab2_timer_ctrl.sv
// Bench for lab2_timer_ctrl: a BCD counter stand-in closes the Q loop, and a
// behavioural timer model predicts every output each cycle.
module tb_lab2_timer_ctrl;
  localparam int TICK_DIV     = 4;
  localparam int ALARM_CYCLES = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  lab2_timer_ctrl_if tif();

  lab2_timer_ctrl #(.TICK_DIV(TICK_DIV), .ALARM_CYCLES(ALARM_CYCLES)) dut (
    .CLK(CLK),
    .RST(RST),
    .tif(tif.slave)
  );

  logic       go, set, cancel;
  logic [3:0] p1, p2;
  int         cnt;

  assign tif.GO        = go;
  assign tif.SET       = set;
  assign tif.CANCEL    = cancel;
  assign tif.PRESET_D1 = p1;
  assign tif.PRESET_D2 = p2;
  assign tif.Q1        = 4'(cnt % 10);
  assign tif.Q2        = 4'(cnt / 10);

  // two-digit BCD counter driven by the DUT, kept as a plain 0..99 integer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt <= 0;
    else if (!tif.CNT_CLR) cnt <= 0;
    else if (tif.CNT_ENABLE) begin
      if (tif.CNT_LOAD) cnt <= int'(tif.CNT_D2) * 10 + int'(tif.CNT_D1);
      else              cnt <= (cnt == 0) ? 99 : cnt - 1;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // reference model: mode numbers follow the documented state encoding
  int mode, run_edges, alarm_left, mcnt, md1, md2;
  bit mgo, mset, mcan;
  int e_load, e_en, e_clr, e_alarm;

  function automatic int clamp9(int v);
    return (v > 9) ? 9 : v;
  endfunction

  task automatic model_reset();
    mode = 0; run_edges = 0; alarm_left = 0; mcnt = 0; md1 = 0; md2 = 0;
    mgo = 0; mset = 0; mcan = 0;
    e_load = 0; e_en = 0; e_clr = 0; e_alarm = 0;
  endtask

  task automatic model_edge();
    bit eg, es, ec, pulse;
    int nxt;
    eg = go && !mgo; es = set && !mset; ec = cancel && !mcan;
    mgo = go; mset = set; mcan = cancel;
    pulse = 0;
    nxt = mode;
    case (mode)
      0: if (ec) nxt = 6; else if (es) nxt = 1;
      1: nxt = 2;
      2: if (ec) nxt = 6; else if (es) nxt = 1;
         else if (eg) begin nxt = 3; run_edges = 0; end
      3: if (ec) nxt = 6; else if (mcnt == 0) nxt = 5; else if (eg) nxt = 4;
         else begin
           run_edges++;
           if (run_edges == TICK_DIV) begin run_edges = 0; pulse = 1; end
         end
      4: if (ec) nxt = 6; else if (es) begin nxt = 1; run_edges = 0; end
         else if (eg) nxt = 3;
      5: begin
           alarm_left--;
           if (eg || ec || alarm_left == 0) nxt = 0;
         end
      default: nxt = 0;
    endcase
    // the counter reacts to the outputs that were present before this edge
    if (e_clr == 0) mcnt = 0;
    else if (e_en != 0) mcnt = (e_load != 0) ? md2 * 10 + md1 : ((mcnt == 0) ? 99 : mcnt - 1);
    if (nxt == 1) begin md1 = clamp9(int'(p1)); md2 = clamp9(int'(p2)); end
    if (nxt == 5 && mode != 5) alarm_left = ALARM_CYCLES;
    mode    = nxt;
    e_load  = (nxt == 1) ? 1 : 0;
    e_en    = (nxt == 1 || pulse) ? 1 : 0;
    e_clr   = (nxt != 6) ? 1 : 0;
    e_alarm = (nxt == 5) ? 1 : 0;
  endtask

  int cyc = 0;
  int en_q[$];
  int alarm_hi, alarm_first;

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    cyc++;
    chk("state", int'(tif.STATE), mode);
    chk("load",  int'(tif.CNT_LOAD), e_load);
    chk("en",    int'(tif.CNT_ENABLE), e_en);
    chk("up",    int'(tif.CNT_UP), 0);
    chk("clr",   int'(tif.CNT_CLR), e_clr);
    chk("alarm", int'(tif.ALARM), e_alarm);
    chk("d1",    int'(tif.CNT_D1), md1);
    chk("d2",    int'(tif.CNT_D2), md2);
    chk("q",     cnt, mcnt);
    if (tif.CNT_ENABLE && !tif.CNT_LOAD) en_q.push_back(cyc);
    if (tif.ALARM) begin
      if (alarm_hi == 0) alarm_first = cyc;
      alarm_hi++;
    end
  endtask

  task automatic press(int b);
    if (b == 0) go = 1'b1; else if (b == 1) set = 1'b1; else cancel = 1'b1;
    step();
    go = 1'b0; set = 1'b0; cancel = 1'b0;
  endtask

  task automatic wait_en(string tag);
    int n;
    n = en_q.size();
    for (int i = 0; i < 20 && en_q.size() == n; i++) step();
    chk(tag, (en_q.size() > n) ? 1 : 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, p, r, n0;
    go = 0; set = 0; cancel = 0; p1 = 0; p2 = 0;
    alarm_hi = 0; alarm_first = 0;
    model_reset();

    // reset values, then CNT_CLR rises one cycle after release
    repeat (3) @(negedge CLK);
    chk("rst_state", int'(tif.STATE), 0);
    chk("rst_clr", int'(tif.CNT_CLR), 0);
    chk("rst_en", int'(tif.CNT_ENABLE), 0);
    #1 RST = 1'b0;
    #1 chk("rel_clr_low", int'(tif.CNT_CLR), 0);
    step();
    chk("rel_clr_high", int'(tif.CNT_CLR), 1);

    // GO in IDLE is ignored
    press(0);
    chk("idle_go_ign", int'(tif.STATE), 0);

    // normal countdown from 03
    p2 = 0; p1 = 3;
    press(1);
    chk("cd_load", int'(tif.CNT_LOAD), 1);
    chk("cd_d1", int'(tif.CNT_D1), 3);
    step();
    press(0);
    t0 = cyc; en_q.delete(); alarm_hi = 0;
    for (int i = 0; i < 60 && tif.STATE != 3'd0; i++) step();
    chk("cd_pulses", en_q.size(), 3);
    if (en_q.size() == 3) begin
      chk("cd_first_tick", en_q[0] - t0, TICK_DIV);
      chk("cd_gap1", en_q[1] - en_q[0], TICK_DIV);
      chk("cd_gap2", en_q[2] - en_q[1], TICK_DIV);
      chk("cd_alarm_at", alarm_first - en_q[2], 2);
    end
    chk("cd_alarm_len", alarm_hi, ALARM_CYCLES);
    chk("cd_idle", int'(tif.STATE), 0);

    // pause/resume with preset 15
    p2 = 1; p1 = 5;
    press(1); step(); press(0);
    wait_en("pr_first_tick");
    p = cyc;
    step(); step(); press(0);
    chk("pr_paused", int'(tif.STATE), 4);
    n0 = en_q.size();
    repeat (20) step();
    chk("pr_no_en", en_q.size() - n0, 0);
    press(0);
    r = cyc;
    wait_en("pr_resume_tick");
    chk("pr_resume_gap", cyc - r, 2);
    step();
    chk("pr_q", cnt, 13);
    press(2); step();

    // clamp to 9 and CANCEL beating GO on the same edge
    p2 = 12; p1 = 10;
    press(1);
    chk("cl_d2", int'(tif.CNT_D2), 9);
    chk("cl_d1", int'(tif.CNT_D1), 9);
    step();
    chk("cl_q", cnt, 99);
    go = 1; cancel = 1;
    step();
    go = 0; cancel = 0;
    chk("pri_clear", int'(tif.STATE), 6);
    chk("pri_clr_low", int'(tif.CNT_CLR), 0);
    step();
    chk("pri_idle", int'(tif.STATE), 0);
    chk("pri_q", cnt, 0);
    chk("pri_clr_high", int'(tif.CNT_CLR), 1);

    // zero preset goes straight to ALARM; GO leaves it
    p2 = 0; p1 = 0;
    press(1); step(); press(0);
    chk("z_run", int'(tif.STATE), 3);
    n0 = en_q.size();
    step();
    chk("z_alarm", int'(tif.STATE), 5);
    chk("z_alarm_out", int'(tif.ALARM), 1);
    chk("z_no_en", en_q.size() - n0, 0);
    step(); press(0);
    chk("z_go_idle", int'(tif.STATE), 0);
    chk("z_alarm_off", int'(tif.ALARM), 0);

    // SET in RUN is ignored and does not disturb the cadence
    p2 = 0; p1 = 9;
    press(1); step(); press(0);
    t0 = cyc; n0 = en_q.size();
    step(); press(1);
    chk("run_set_ign", int'(tif.STATE), 3);
    repeat (6) step();
    chk("run_set_pulses", en_q.size() - n0, 2);
    if (en_q.size() - n0 == 2) begin
      chk("run_set_t1", en_q[n0] - t0, TICK_DIV);
      chk("run_set_t2", en_q[n0 + 1] - t0, 2 * TICK_DIV);
    end

    // asynchronous reset while running
    repeat (2) step();
    #2 RST = 1'b1;
    #1;
    chk("arst_state", int'(tif.STATE), 0);
    chk("arst_clr", int'(tif.CNT_CLR), 0);
    chk("arst_en", int'(tif.CNT_ENABLE), 0);
    chk("arst_load", int'(tif.CNT_LOAD), 0);
    chk("arst_alarm", int'(tif.ALARM), 0);
    chk("arst_d1", int'(tif.CNT_D1), 0);
    model_reset();
    @(negedge CLK);
    #1 RST = 1'b0;
    #1 chk("arst_rel_clr_low", int'(tif.CNT_CLR), 0);
    step();
    chk("arst_rel_clr_high", int'(tif.CNT_CLR), 1);

    // randomized button activity against the model
    for (int i = 0; i < 1500; i++) begin
      go     = ($urandom_range(0, 9) == 0);
      set    = ($urandom_range(0, 15) == 0);
      cancel = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) begin
        p1 = 4'($urandom_range(0, 15));
        p2 = 4'($urandom_range(0, 2));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/lab2_timer_ctrl.md
# lab2_timer_ctrl

Countdown-timer controller that sequences the two-digit BCD counter (`lab2bcd_2digit`) as a kitchen-style timer. It loads a user preset into the counter and issues one down-count enable pulse per prescaled tick. It pauses and resumes on a button, raises a timed alarm at 00, and clears the counter on cancel. It sits between the board buttons/switches and the counter, sharing the counter's clock.

## Interface
- TICK_DIV, 100000000: CLK cycles per count step (≥2); prescaler width is $clog2(TICK_DIV).
- ALARM_CYCLES, 300000000: maximum cycles ALARM stays high.
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous and active-high.
- GO  in  1  start/pause/resume button (level, synchronous to CLK).
- SET  in  1  load-preset button (level, synchronous).
- CANCEL  in  1  abort/clear button (level, synchronous).
- PRESET_D1  in  4  preset ones digit.
- PRESET_D2  in  4  preset tens digit.
- Q1  in  4  counter ones digit (from counter).
- Q2  in  4  counter tens digit (from counter).
- CNT_D1  out  4  counter load data, ones.
- CNT_D2  out  4  counter load data, tens.
- CNT_LOAD  out  1  counter LOAD.
- CNT_ENABLE  out  1  counter ENABLE.
- CNT_UP  out  1  counter UP; constant 0.
- CNT_CLR  out  1  counter CLR, active-low.
- ALARM  out  1  alarm indicator.
- STATE  out  3  current state encoding (debug).

## Operation
- Edge detect: GO, SET and CANCEL each have a prev register, reset to 0. An event is `in & ~prev`, acted on at the same rising edge. A button held high through reset release counts as one event.
- Event priority when simultaneous: CANCEL > SET > GO.
- States: IDLE=0, LOAD=1, READY=2, RUN=3, PAUSE=4, ALARM=5, CLEAR=6.
- IDLE:
  - SET → LOAD.
  - CANCEL → CLEAR.
  - GO is ignored.
- LOAD:
  - Lasts exactly one cycle, with CNT_LOAD=1 and CNT_ENABLE=1.
  - CNT_D1/CNT_D2 hold the presets captured on the SET edge. Any digit >9 is clamped to 9.
  - Always → READY.
- READY:
  - GO → RUN, with the prescaler cleared to 0.
  - SET → LOAD.
  - CANCEL → CLEAR.
- RUN:
  - The prescaler counts 0..TICK_DIV-1 and wraps.
  - When the prescaler is at TICK_DIV-1 and {Q2,Q1}≠00, CNT_ENABLE is high the following cycle, for one cycle only. CNT_LOAD=0, CNT_UP=0.
  - If {Q2,Q1}==00 is sampled at any edge → ALARM; no enable pulse is issued.
  - GO → PAUSE, and the prescaler holds its value.
  - SET is ignored.
  - CANCEL → CLEAR.
- PAUSE:
  - CNT_ENABLE=0.
  - GO → RUN, resuming from the held prescaler value.
  - SET → LOAD, and the prescaler is cleared.
  - CANCEL → CLEAR.
- ALARM:
  - ALARM=1 and the alarm counter runs.
  - After ALARM_CYCLES cycles, or on a GO or CANCEL event, → IDLE. Cancel here does not pass through CLEAR, since the counter is already 00.
- CLEAR:
  - Lasts one cycle with CNT_CLR=0.
  - Always → IDLE.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Timing
- During RST and on the first cycle after release:
  - STATE=0.
  - CNT_CLR=0, holding the counter cleared.
  - CNT_LOAD=0, CNT_ENABLE=0, CNT_UP=0.
  - CNT_D1=CNT_D2=0, ALARM=0.
  - Prescaler and alarm counter are 0.
- From the second cycle after release, CNT_CLR=1.
- RST asserted mid-operation returns everything to the reset values immediately, without waiting for a clock edge.
- Tick spacing:
  - The first enable pulse is TICK_DIV cycles after the edge that entered RUN; subsequent pulses are TICK_DIV cycles apart.
  - Pause time is excluded from this count.
- Zero detect: for the pulse that produces 00, the counter updates at edge t+1 and the controller sees 00 and enters ALARM at edge t+2. Here t is the first edge at which CNT_ENABLE is high.
- Entering RUN with a 00 preset → ALARM on the next edge, with zero enable pulses.
- ALARM is high for exactly ALARM_CYCLES cycles when not interrupted.
- Wrap-around: the prescaler and alarm counter never overflow their widths.

## Test plan
- Reset mid-operation (TICK_DIV=4, ALARM_CYCLES=8): raise RST while in RUN → outputs immediately at reset values, with STATE=0 and CNT_CLR=0. After release, CNT_CLR rises one cycle later.
- Normal countdown: PRESET=0,3 (D2=0, D1=3), pulse SET then GO → one LOAD cycle with CNT_D1=3, then 3 CNT_ENABLE pulses 4 cycles apart. The counter reads 02, 01, 00; ALARM is high 2 cycles after the third pulse for exactly 8 cycles, then STATE=0.
- Pause/resume: with preset 15, pause via GO 2 cycles after the first pulse and hold 20 cycles → no CNT_ENABLE while paused. Resume with GO → the next pulse arrives 2 cycles after resume, and the counter reads 13 after it.
- Clamp and priority: PRESET_D2=12, D1=10, SET → CNT_D2=9 and CNT_D1=9 during LOAD, and the counter reads 99. Then GO and CANCEL on the same edge in READY → CLEAR (CNT_CLR=0 for one cycle), counter reads 00, then IDLE.
- Zero preset: SET with 00, then GO → ALARM on the edge after entering RUN, with no CNT_ENABLE pulse. A GO edge during ALARM → IDLE and ALARM=0 the next cycle.
- Ignored events: GO in IDLE and SET in RUN → no state change, and the tick cadence is unchanged.
